// File: rtl/trigger_qualifier_if.sv
// Handshake/bus bundle between the trigger qualifier and its environment.
// Define TRIGGER_QUALIFIER_TIMESTAMP_EN to add the trig_timestamp signal.
interface trigger_qualifier_if #(
  parameter int HOLDOFF_W = 16,
  parameter int COUNT_W   = 16
);
  logic                 trig_in;
  logic                 arm;
  logic                 ready_flag;
  logic [HOLDOFF_W-1:0] holdoff_cycles;
  logic                 clear_counters;
  logic                 run_sequencer;
  logic                 busy;
  logic                 ack_error;
  logic [COUNT_W-1:0]   accepted_count;
  logic [COUNT_W-1:0]   rejected_count;
`ifdef TRIGGER_QUALIFIER_TIMESTAMP_EN
  logic [31:0]          trig_timestamp;
`endif

  modport master (
    output trig_in, arm, ready_flag, holdoff_cycles, clear_counters,
    input  run_sequencer, busy, ack_error, accepted_count, rejected_count
`ifdef TRIGGER_QUALIFIER_TIMESTAMP_EN
    , input trig_timestamp
`endif
  );

  modport slave (
    input  trig_in, arm, ready_flag, holdoff_cycles, clear_counters,
    output run_sequencer, busy, ack_error, accepted_count, rejected_count
`ifdef TRIGGER_QUALIFIER_TIMESTAMP_EN
    , output trig_timestamp
`endif
  );
endinterface

// File: rtl/trigger_qualifier.sv
// Synchronises, width-filters and qualifies the DIO34 trigger into a one-cycle sequencer
// start pulse with hold-off and accept/reject counters. TRIGGER_QUALIFIER_TIMESTAMP_EN adds timestamps.
module trigger_qualifier #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_WIDTH   = 2,
  parameter int HOLDOFF_W   = 16,
  parameter int COUNT_W     = 16,
  parameter int ACK_TIMEOUT = 4
) (
  input logic clk,
  input logic res_n,
  trigger_qualifier_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ARMED, FIRE, WAIT_ACK, WAIT_DONE, HOLDOFF} state_e;

  state_e               state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 synced, evt;
  logic [3:0]           wcnt_q, wcnt_d;
  logic [3:0]           ack_cnt_q, ack_cnt_d;
  logic [HOLDOFF_W-1:0] hcnt_q, hcnt_d;
  logic                 run_q, busy_q, ack_err_q, ack_err_d, ack_set;
  logic                 acc_inc, rej_inc;
  logic [COUNT_W-1:0]   acc_q, acc_d, rej_q, rej_d;

  assign synced = sync_q[SYNC_STAGES-1];
  // Width counter parks at MIN_WIDTH so a long pulse yields exactly one event.
  assign evt    = synced && (wcnt_q == 4'(MIN_WIDTH-1));

  always_comb begin
    wcnt_d = wcnt_q;
    if (!synced)                     wcnt_d = '0;
    else if (wcnt_q != 4'(MIN_WIDTH)) wcnt_d = wcnt_q + 4'd1;
  end

  always_comb begin
    state_d   = state_q;
    ack_cnt_d = ack_cnt_q;
    hcnt_d    = hcnt_q;
    ack_set   = 1'b0;
    acc_inc   = 1'b0;
    case (state_q)
      IDLE:      if (bus.arm) state_d = ARMED;
      ARMED: begin
        if (!bus.arm)                      state_d = IDLE;
        else if (evt && bus.ready_flag)    state_d = FIRE;
      end
      FIRE: begin
        acc_inc   = 1'b1;
        ack_cnt_d = '0;
        state_d   = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (!bus.ready_flag) state_d = WAIT_DONE;
        else if (ack_cnt_q == 4'(ACK_TIMEOUT-1)) begin
          ack_set = 1'b1;
          hcnt_d  = bus.holdoff_cycles;
          state_d = HOLDOFF;
        end else ack_cnt_d = ack_cnt_q + 4'd1;
      end
      WAIT_DONE: begin
        if (bus.ready_flag) begin
          hcnt_d  = bus.holdoff_cycles;
          state_d = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (!bus.arm)          state_d = IDLE;
        else if (hcnt_q == '0) state_d = ARMED;
        else                   hcnt_d  = hcnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Any qualified edge not turned into a fire is a reject, but only while armed.
  assign rej_inc = evt && bus.arm && !(state_q == ARMED && bus.ready_flag);

  always_comb begin
    acc_d     = acc_q;
    rej_d     = rej_q;
    ack_err_d = ack_err_q | ack_set;
    if (bus.clear_counters) begin
      acc_d     = '0;
      rej_d     = '0;
      ack_err_d = 1'b0;
    end else begin
      if (acc_inc && acc_q != '1) acc_d = acc_q + 1'b1;
      if (rej_inc && rej_q != '1) rej_d = rej_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q   <= IDLE;
      sync_q    <= '0;
      wcnt_q    <= '0;
      ack_cnt_q <= '0;
      hcnt_q    <= '0;
      run_q     <= 1'b0;
      busy_q    <= 1'b0;
      ack_err_q <= 1'b0;
      acc_q     <= '0;
      rej_q     <= '0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.trig_in};
      wcnt_q    <= wcnt_d;
      ack_cnt_q <= ack_cnt_d;
      hcnt_q    <= hcnt_d;
      // Outputs registered from next state so reset can force them all low.
      run_q     <= (state_d == FIRE);
      busy_q    <= (state_d != ARMED);
      ack_err_q <= ack_err_d;
      acc_q     <= acc_d;
      rej_q     <= rej_d;
    end
  end

  assign bus.run_sequencer  = run_q;
  assign bus.busy           = busy_q;
  assign bus.ack_error      = ack_err_q;
  assign bus.accepted_count = acc_q;
  assign bus.rejected_count = rej_q;

`ifdef TRIGGER_QUALIFIER_TIMESTAMP_EN
  logic [31:0] ts_cnt_q, ts_q;
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      ts_cnt_q <= '0;
      ts_q     <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 32'd1;
      if (state_q == FIRE) ts_q <= ts_cnt_q;
    end
  end
  assign bus.trig_timestamp = ts_q;
`endif
endmodule
